// File: rtl/seq_stream_arbiter.sv
// Round-robin front end that serializes one requester word at a time, MSB first, into a shared
// sequence recognizer and counts its matches per requester. Define SEQ_ARB_FIXED_PRIO_EN for fixed
// priority (req0 always wins ties, no pointer state).
module seq_stream_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clock,
  input  logic             _reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  output logic             ack0,
  output logic [CNT_W-1:0] hits0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             ack1,
  output logic [CNT_W-1:0] hits1,
  output logic             ser_out,
  input  logic             rec_match,
  output logic             busy,
  output logic             grant
);

  localparam int unsigned BitW = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] HitMax = '1;
  localparam logic [BitW-1:0] LastBit = BitW'(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BitW-1:0]  bitcnt_q, bitcnt_d;
  logic             grant_q, grant_d;
  logic             ser_q, ser_d;
  logic             busy_q, busy_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic [CNT_W-1:0] hits0_q, hits0_d;
  logic [CNT_W-1:0] hits1_q, hits1_d;
  logic             winner;
  logic [WIDTH-1:0] win_data;

`ifdef SEQ_ARB_FIXED_PRIO_EN
  assign winner = ~req0;
`else
  // last_q holds the requester served most recently; a tie goes to the other one.
  logic last_q, last_d;

  assign winner = (req0 && req1) ? ~last_q : ~req0;

  always_comb begin
    last_d = last_q;
    if (state_q == StDone) begin
      last_d = grant_q;
    end
  end

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign win_data = winner ? data1 : data0;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    grant_d  = grant_q;
    ser_d    = ser_q;
    busy_d   = busy_q;
    ack0_d   = ack0_q;
    ack1_d   = ack1_q;
    hits0_d  = hits0_q;
    hits1_d  = hits1_q;

    unique case (state_q)
      StIdle: begin
        ser_d = 1'b1;
        if (req0 || req1) begin
          grant_d  = winner;
          busy_d   = 1'b1;
          ser_d    = win_data[WIDTH-1];
          shreg_d  = {win_data[WIDTH-2:0], 1'b0};
          bitcnt_d = BitW'(1);
          state_d  = StShift;
        end
      end
      StShift: begin
        // Every SHIFT edge samples the recognizer: E1..E_WIDTH, WIDTH samples per word.
        if (rec_match) begin
          if (grant_q) begin
            hits1_d = (hits1_q == HitMax) ? hits1_q : hits1_q + CNT_W'(1);
          end else begin
            hits0_d = (hits0_q == HitMax) ? hits0_q : hits0_q + CNT_W'(1);
          end
        end
        if (bitcnt_q == LastBit) begin
          ser_d   = 1'b1;
          ack0_d  = ~grant_q;
          ack1_d  = grant_q;
          state_d = StDone;
        end else begin
          ser_d    = shreg_q[WIDTH-1];
          shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
          bitcnt_d = bitcnt_q + BitW'(1);
        end
      end
      StDone: begin
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      state_q  <= StIdle;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      grant_q  <= 1'b0;
      ser_q    <= 1'b1;
      busy_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      hits0_q  <= '0;
      hits1_q  <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      grant_q  <= grant_d;
      ser_q    <= ser_d;
      busy_q   <= busy_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      hits0_q  <= hits0_d;
      hits1_q  <= hits1_d;
    end
  end

  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign hits0   = hits0_q;
  assign hits1   = hits1_q;
  assign ser_out = ser_q;
  assign busy    = busy_q;
  assign grant   = grant_q;

endmodule
